// File: rtl/venc_frame_ctrl_pkg.sv
// Shared types and constants for the framed rate-1/2 convolutional encoder.
// Holds the FSM state encoding, the generator polynomials and the tail length.
package venc_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  localparam int unsigned ENC_K    = 3;
  localparam logic [2:0]  GEN_G0   = 3'b111;
  localparam logic [2:0]  GEN_G1   = 3'b101;
  localparam int unsigned TAIL_LEN = ENC_K - 1;

  // The window is ordered {newest bit, s1, s2}, so generator bit 2 taps the input.
  function automatic logic gen_parity(input logic [2:0] window, input logic [2:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Shift register and generator XORs for the K=3 convolutional code.
// The window keeps the most recently shifted bit, so c0/c1 stay valid for the whole symbol pair.
module conv_enc_core
  import venc_frame_ctrl_pkg::*;
#(
  parameter int K = ENC_K
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_bit,
  output logic o_c0,
  output logic o_c1
);

  logic [K-1:0] r_window;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_window <= '0;
    end else if (i_clr) begin
      r_window <= '0;
    end else if (i_en) begin
      r_window <= {i_bit, r_window[K-1:1]};
    end
  end

  assign o_c0 = gen_parity(r_window, GEN_G0);
  assign o_c1 = gen_parity(r_window, GEN_G1);

endmodule

// File: rtl/venc_frame_ctrl.sv
// Frame controller for a rate-1/2 K=3 convolutional encoder: accepts FRAME_LEN bits,
// appends K-1 zero tail bits and streams c0/c1 symbol pairs under a valid/ready handshake.
module venc_frame_ctrl
  import venc_frame_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int K         = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_in_valid,
  input  logic i_in_data,
  output logic o_in_ready,
  output logic o_out_valid,
  output logic o_out_bit,
  input  logic i_out_ready,
  output logic o_out_last,
  output logic o_busy,
  output logic o_done
);

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int TCNT_W = $clog2(TAIL_LEN + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_pending;
  logic                r_phase;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic [TCNT_W-1:0]   r_tail_cnt;

  logic w_start_ok;
  logic w_abort;
  logic w_in_fire;
  logic w_out_fire;
  logic w_pair_done;
  logic w_last_data;
  logic w_last_tail;
  logic w_tail_shift;
  logic w_enc_en;
  logic w_enc_clr;
  logic w_enc_bit;
  logic w_c0;
  logic w_c1;

  assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_abort     = (r_state != ST_IDLE) && i_abort;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_out_fire  = o_out_valid && i_out_ready;
  assign w_pair_done = w_out_fire && r_phase;
  assign w_last_data = (r_state == ST_DATA) && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_last_tail = (r_state == ST_TAIL) && (r_tail_cnt == TCNT_W'(TAIL_LEN - 1));

  // A zero tail bit is shifted on the same edge that retires the previous pair,
  // so the next tail symbol is presented without a bubble.
  assign w_tail_shift = w_pair_done && (w_last_data || ((r_state == ST_TAIL) && !w_last_tail));

  assign w_enc_en  = w_in_fire || w_tail_shift;
  assign w_enc_bit = w_in_fire && i_in_data;
  assign w_enc_clr = w_start_ok || w_abort;

  conv_enc_core #(
    .K (K)
  ) u_enc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_enc_en),
    .i_clr   (w_enc_clr),
    .i_bit   (w_enc_bit),
    .o_c0    (w_c0),
    .o_c1    (w_c1)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (i_abort)                         w_state_nxt = ST_IDLE;
        else if (w_pair_done && w_last_data) w_state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        if (i_abort)                         w_state_nxt = ST_IDLE;
        else if (w_pair_done && w_last_tail) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    o_in_ready  = (r_state == ST_DATA) && !r_pending;
    o_out_valid = r_pending;
    o_out_bit   = r_pending && (r_phase ? w_c1 : w_c0);
    o_out_last  = r_pending && r_phase && w_last_tail;
    o_done      = r_done;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending  <= 1'b0;
      r_phase    <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_tail_cnt <= '0;
    end else begin
      r_done <= w_pair_done && w_last_tail && !i_abort;
      if (w_start_ok || w_abort) begin
        r_pending  <= 1'b0;
        r_phase    <= 1'b0;
        r_cnt      <= '0;
        r_tail_cnt <= '0;
      end else if (w_in_fire) begin
        r_pending <= 1'b1;
        r_phase   <= 1'b0;
      end else if (w_out_fire) begin
        if (!r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_pending <= w_tail_shift;
          if (r_state == ST_DATA) r_cnt      <= r_cnt + CNT_W'(1);
          else                    r_tail_cnt <= r_tail_cnt + TCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_venc_frame_ctrl.sv
// Directed bench for venc_frame_ctrl with FRAME_LEN=4: clean frames, stalls, ignored start,
// abort and reset mid-tail, each against hand-computed symbol streams.
module tb_venc_frame_ctrl;

  localparam int FL = 4;

  // Input 1,0,1,1 -> 11 10 00 01 01 11 (first symbol in the MSB).
  localparam logic [11:0] SYMS_1011 = 12'b11_10_00_01_01_11;
  localparam logic [11:0] SYMS_0000 = 12'b00_00_00_00_00_00;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic abort    = 1'b0;
  logic in_valid = 1'b0;
  logic in_data  = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_bit, out_last, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  venc_frame_ctrl #(
    .FRAME_LEN (FL),
    .K         (3)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_bit   (out_bit),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_bit"},   32'(out_bit),   32'd0);
    check({tag, " out_last"},  32'(out_last),  32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  // Runs one frame (bits MSB first) until stop_after symbols are accepted; a full
  // frame (12 symbols) also checks the done pulse and the return to idle.
  task automatic run_frame(input string tag, input logic [FL-1:0] bits, input logic [11:0] exp,
                           input bit stall, input bit poke_start, input int stop_after);
    int   nbit = 0;
    int   nsym = 0;
    int   cyc  = 0;
    bit   stalled = 1'b0;
    logic held = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    while (nsym < stop_after && cyc < 400) begin
      if (stalled) begin
        check({tag, " stall valid"}, 32'(out_valid), 32'd1);
        check({tag, " stall bit"},   32'(out_bit),   32'(held));
      end
      if (nbit < FL) begin
        in_valid = 1'b1;
        in_data  = bits[FL-1-nbit];
      end else begin
        in_valid = 1'b0;
        in_data  = 1'b0;
      end
      out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
      start     = poke_start && (cyc == 3);
      stalled   = out_valid && !out_ready;
      held      = out_bit;
      if (in_ready && in_valid) nbit++;
      if (out_valid && out_ready) begin
        check($sformatf("%s sym%0d", tag, nsym),  32'(out_bit),  32'(exp[11-nsym]));
        check($sformatf("%s last%0d", tag, nsym), 32'(out_last), 32'(nsym == 11));
        nsym++;
      end
      step();
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, " symbol count"}, 32'(nsym), 32'(stop_after));
    if (stop_after == 12) begin
      check({tag, " done pulse"}, 32'(done), 32'd1);
      step();
      check({tag, " done clears"}, 32'(done), 32'd0);
      check({tag, " idle busy"},   32'(busy), 32'd0);
    end
  endtask

  initial begin
    #3;
    check_all_low("reset");
    check("reset window", 32'(dut.u_enc.r_window), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_all_low("idle");

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start+abort ignored", 32'(busy), 32'd0);

    run_frame("frameA", 4'b1011, SYMS_1011, 1'b0, 1'b0, 12);
    run_frame("zeros",  4'b0000, SYMS_0000, 1'b0, 1'b0, 12);
    check("zeros final state", 32'(dut.u_enc.r_window[2:1]), 32'd0);
    run_frame("stall",  4'b1011, SYMS_1011, 1'b1, 1'b0, 12);
    run_frame("poke",   4'b1011, SYMS_1011, 1'b0, 1'b1, 12);

    run_frame("abort", 4'b1011, SYMS_1011, 1'b0, 1'b0, 2);
    check("abort pre in_ready", 32'(in_ready), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort busy",      32'(busy),      32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready",  32'(in_ready),  32'd0);
    check("abort out_last",  32'(out_last),  32'd0);
    check("abort state",     32'(dut.u_enc.r_window), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort no done %0d", i), 32'(done), 32'd0);
      step();
    end
    run_frame("after abort", 4'b1011, SYMS_1011, 1'b0, 1'b0, 12);

    run_frame("rst tail", 4'b1011, SYMS_1011, 1'b0, 1'b0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("mid-tail reset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post reset busy %0d", i),  32'(busy),      32'd0);
      check($sformatf("post reset valid %0d", i), 32'(out_valid), 32'd0);
    end
    run_frame("after reset", 4'b1011, SYMS_1011, 1'b0, 1'b0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
